// File: rtl/snitch_pkg.sv
// Shared Snitch types: per-core event strobes and the performance-counter configuration layout.
package snitch_pkg;

    // Event index e selects bit e (LSB first), so the struct is declared from MSB down.
    typedef struct packed {
        logic issue_fpu;          // 6
        logic issue_fpu_seq;      // 5
        logic issue_core_to_fpu;  // 4
        logic retired_instr;      // 3
        logic retired_load;       // 2
        logic retired_i;          // 1
        logic retired_acc;        // 0
    } core_events_t;

    typedef struct packed {
        logic [7:0] hart;
        logic [2:0] event_idx;
        logic       enable;
    } perf_cnt_cfg_t;

    localparam int unsigned NumCoreEvents = $bits(core_events_t);

    localparam logic [1:0] PerfCfgOff   = 2'd0;
    localparam logic [1:0] PerfValLoOff = 2'd1;
    localparam logic [1:0] PerfValHiOff = 2'd2;

    // CFG register image: [0] enable, [6:4] event index, [15:8] hart, rest zero.
    function automatic logic [31:0] perf_cfg_to_word(perf_cnt_cfg_t cfg);
        return {16'h0000, cfg.hart, 1'b0, cfg.event_idx, 3'b000, cfg.enable};
    endfunction

endpackage

// File: rtl/snitch_perf_counter.sv
// One programmable event counter: CFG register, hart/event selection, wrap-around increment,
// software write override and the HI-word shadow captured on VAL_LO reads.
module snitch_perf_counter
    import snitch_pkg::*;
#(
    parameter int unsigned NumCores = 8,
    parameter int unsigned CntWidth = 48
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NumCores-1:0][NumCoreEvents-1:0]  events,
    input  logic                                    wr_en,
    input  logic [1:0]                              wr_reg,
    input  logic [31:0]                             wdata,
    input  logic                                    rd_lo,
    output perf_cnt_cfg_t                           cfg,
    output logic [CntWidth-1:0]                     value,
    output logic [CntWidth-33:0]                    hi_shadow
);

    localparam int unsigned HiW = CntWidth - 32;

    logic strobe;

    // Out-of-range hart or event index matches no iteration, so the strobe stays low.
    always_comb begin
        strobe = 1'b0;
        for (int h = 0; h < NumCores; h++) begin
            for (int e = 0; e < NumCoreEvents; e++) begin
                if (cfg.hart == 8'(h) && cfg.event_idx == 3'(e)) begin
                    strobe = events[h][e];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg       <= '0;
            value     <= '0;
            hi_shadow <= '0;
        end else begin
            // Snapshot of the pre-increment value keeps a LO-then-HI read pair coherent.
            if (rd_lo) begin
                hi_shadow <= value[CntWidth-1:32];
            end
            if (wr_en && wr_reg == PerfCfgOff) begin
                cfg.hart      <= wdata[15:8];
                cfg.event_idx <= wdata[6:4];
                cfg.enable    <= wdata[0];
            end
            // A software write to the value always beats a coincident increment.
            if (wr_en && wr_reg == PerfValLoOff) begin
                value <= {value[CntWidth-1:32], wdata};
            end else if (wr_en && wr_reg == PerfValHiOff) begin
                value <= {wdata[HiW-1:0], value[31:0]};
            end else if (cfg.enable && strobe) begin
                value <= value + CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/snitch_perf_event_counters.sv
// Cluster performance-counter unit: registers the per-hart event strobes, decodes the 32-bit
// register port onto NumCounters counters and returns one response per accepted request.
module snitch_perf_event_counters
    import snitch_pkg::*;
#(
    parameter int unsigned NumCores    = 8,
    parameter int unsigned NumCounters = 4,
    parameter int unsigned CntWidth    = 48
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumCores*NumCoreEvents-1:0] events_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic                              req_write_i,
    input  logic [7:0]                        req_addr_i,
    input  logic [31:0]                       req_wdata_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [31:0]                       rsp_rdata_o,
    output logic                              rsp_error_o
);

    logic [NumCores-1:0][NumCoreEvents-1:0] events_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            events_q <= '0;
        end else begin
            events_q <= events_i;
        end
    end

    // Handshake: a request transfers on a cycle with req_valid_i && req_ready_o; its response
    // appears the cycle after and is held stable until a cycle with rsp_valid_o && rsp_ready_i.
    // At most one transaction is outstanding, so a new request may only be accepted in the
    // same cycle the pending response is consumed.
    logic       accept;
    logic [3:0] cnt_sel;
    logic [1:0] reg_sel;
    logic       addr_err;
    logic       unused_addr_bits;

    assign req_ready_o      = !rsp_valid_o || rsp_ready_i;
    assign accept           = req_valid_i && req_ready_o;
    assign cnt_sel          = req_addr_i[7:4];
    assign reg_sel          = req_addr_i[3:2];
    assign addr_err         = (reg_sel == 2'd3) || ({1'b0, cnt_sel} >= 5'(NumCounters));
    assign unused_addr_bits = ^req_addr_i[1:0];

    perf_cnt_cfg_t        cfg       [NumCounters];
    logic [CntWidth-1:0]  value     [NumCounters];
    logic [CntWidth-33:0] hi_shadow [NumCounters];

    for (genvar k = 0; k < NumCounters; k++) begin : gen_cnt
        logic sel;
        assign sel = accept && !addr_err && (cnt_sel == 4'(k));

        snitch_perf_counter #(
            .NumCores (NumCores),
            .CntWidth (CntWidth)
        ) i_counter (
            .clk       (clk_i),
            .rst       (rst_i),
            .events    (events_q),
            .wr_en     (sel && req_write_i),
            .wr_reg    (reg_sel),
            .wdata     (req_wdata_i),
            .rd_lo     (sel && !req_write_i && (reg_sel == PerfValLoOff)),
            .cfg       (cfg[k]),
            .value     (value[k]),
            .hi_shadow (hi_shadow[k])
        );
    end

    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NumCounters; k++) begin
            if (cnt_sel == 4'(k)) begin
                case (reg_sel)
                    PerfCfgOff:   rdata_d = perf_cfg_to_word(cfg[k]);
                    PerfValLoOff: rdata_d = value[k][31:0];
                    PerfValHiOff: rdata_d = 32'(hi_shadow[k]);
                    default:      rdata_d = '0;
                endcase
            end
        end
        if (addr_err || req_write_i) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
        end else if (accept) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rdata_d;
            rsp_error_o <= addr_err;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snitch_perf_event_counters.sv
// Directed bench for snitch_perf_event_counters with a transaction-level reference model.
module tb_snitch_perf_event_counters;

    localparam int NC = 8;
    localparam int NK = 4;
    localparam int CW = 48;
    localparam int EW = NC * 7;
    localparam longint unsigned CNT_MASK = (64'd1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [EW-1:0] events    = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [7:0]    req_addr  = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;

    snitch_perf_event_counters #(
        .NumCores    (NC),
        .NumCounters (NK),
        .CntWidth    (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .events_i    (events),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint unsigned m_cnt  [NK];
    longint unsigned m_hi   [NK];
    bit              m_en   [NK];
    int              m_idx  [NK];
    int              m_hart [NK];
    logic [EW-1:0]   m_ev_q;
    bit              m_valid;
    logic [31:0]     m_rdata;
    bit              m_err;

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit bad;
        bit wr_hit;
        int c;
        int r;
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                m_cnt[k] = 0; m_hi[k] = 0; m_en[k] = 0; m_idx[k] = 0; m_hart[k] = 0;
            end
            m_ev_q = '0; m_valid = 0; m_rdata = '0; m_err = 0;
        end else begin
            acc = req_valid && (!m_valid || rsp_ready);
            c   = int'(req_addr[7:4]);
            r   = int'(req_addr[3:2]);
            bad = (r == 3) || (c >= NK);
            if (acc) begin
                m_valid = 1; m_err = bad; m_rdata = '0;
                if (!bad && !req_write) begin
                    if (r == 0) m_rdata = {16'h0, 8'(m_hart[c]), 1'b0, 3'(m_idx[c]), 3'b0, m_en[c]};
                    if (r == 1) begin
                        m_rdata = m_cnt[c][31:0];
                        m_hi[c] = m_cnt[c] >> 32;
                    end
                    if (r == 2) m_rdata = m_hi[c][31:0];
                end
            end else if (rsp_ready) begin
                m_valid = 0;
            end
            for (int k = 0; k < NK; k++) begin
                wr_hit = acc && !bad && req_write && (c == k) && (r != 0);
                if (wr_hit && r == 1)
                    m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | longint'(req_wdata);
                else if (wr_hit && r == 2)
                    m_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF) | (longint'(req_wdata[15:0]) << 32);
                else if (m_en[k] && m_idx[k] < 7 && m_hart[k] < NC)
                    if (m_ev_q[m_hart[k] * 7 + m_idx[k]]) m_cnt[k] = (m_cnt[k] + 1) & CNT_MASK;
            end
            if (acc && !bad && req_write && r == 0) begin
                m_en[c] = req_wdata[0]; m_idx[c] = int'(req_wdata[6:4]); m_hart[c] = int'(req_wdata[15:8]);
            end
            m_ev_q = events;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("rsp_valid", {63'b0, rsp_valid}, {63'b0, m_valid});
            check("req_ready", {63'b0, req_ready}, {63'b0, (!m_valid || rsp_ready)});
            if (m_valid) begin
                check("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, m_rdata});
                check("rsp_error", {63'b0, rsp_error}, {63'b0, m_err});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int n;
        bit acc;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        n = 0; acc = 0;
        while (!acc && n < 50) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1; n++;
        end
        req_valid = 1'b0; req_write = 1'b0;
        check("req_accept", {63'b0, acc}, 64'd1);
        @(negedge clk);
        check("rsp_seen", {63'b0, rsp_valid}, 64'd1);
        rd = rsp_rdata; er = rsp_error;
    endtask

    task automatic rd_expect(input string name, input logic [7:0] addr,
                             input logic [31:0] exp, input logic exp_err);
        logic [31:0] rd;
        logic er;
        do_req(1'b0, addr, 32'h0, rd, er);
        check(name, {32'b0, rd}, {32'b0, exp});
        check({name, "_err"}, {63'b0, er}, {63'b0, exp_err});
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic er;
        do_req(1'b1, addr, wd, rd, er);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [EW-1:0] ev;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("reset_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
        check("reset_rsp_error", {63'b0, rsp_error}, 64'd0);
        check("reset_req_ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk); #1 rst = 1'b0;

        // All registers read zero after reset.
        for (int c = 0; c < NK; c++)
            for (int r = 0; r < 3; r++)
                rd_expect("reset_reg", 8'(c * 16 + r * 4), 32'h0, 1'b0);

        // Counter 0: hart 3 retired_acc; counter 3: hart 2 issue_fpu; counters 1/2 unreachable.
        wr_reg(8'h00, 32'h0000_0301);
        wr_reg(8'h10, 32'h0000_0901);
        wr_reg(8'h20, 32'h0000_0271);
        wr_reg(8'h30, 32'h0000_0261);
        rd_expect("cfg0_readback", 8'h00, 32'h0000_0301, 1'b0);
        rd_expect("cfg2_readback", 8'h20, 32'h0000_0271, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            ev = '0;
            ev[3 * 7] = 1'b1;
            ev[2 * 7 +: 7] = (i % 2 == 1) ? 7'h7F : 7'h00;
            events = ev;
            @(posedge clk); #1;
        end
        events = '0;
        rd_expect("cnt0_ten", 8'h04, 32'd10, 1'b0);
        rd_expect("cnt1_bad_hart", 8'h14, 32'd0, 1'b0);
        rd_expect("cnt2_bad_event", 8'h24, 32'd0, 1'b0);
        rd_expect("cnt3_toggle", 8'h34, 32'd5, 1'b0);

        // Wrap from 2^48-2 by three strobes.
        wr_reg(8'h08, 32'h0000_FFFF);
        wr_reg(8'h04, 32'hFFFF_FFFE);
        rd_expect("pre_wrap_lo", 8'h04, 32'hFFFF_FFFE, 1'b0);
        rd_expect("pre_wrap_hi", 8'h08, 32'h0000_FFFF, 1'b0);
        @(posedge clk); #1;
        ev = '0; ev[3 * 7] = 1'b1; events = ev;
        repeat (3) begin @(posedge clk); #1; end
        events = '0;
        rd_expect("wrap_lo", 8'h04, 32'd1, 1'b0);
        rd_expect("wrap_hi", 8'h08, 32'd0, 1'b0);

        // VAL_LO write lands on the same edge as an increment: the write wins.
        @(posedge clk); #1;
        events = ev;
        @(posedge clk); #1;
        events = '0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h04; req_wdata = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
        rd_expect("write_wins", 8'h04, 32'h100, 1'b0);

        // Backpressure: response held, no new request taken.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 8'h04;
        @(posedge clk); #1;
        req_addr = 8'h34;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", {63'b0, req_ready}, 64'd0);
            check("bp_rsp_valid", {63'b0, rsp_valid}, 64'd1);
            check("bp_rsp_rdata", {32'b0, rsp_rdata}, 64'h100);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_second_rsp", {32'b0, rsp_rdata}, 64'd5);

        // Decode errors: no data, no side effects.
        rd_expect("err_r3", 8'h0C, 32'h0, 1'b1);
        rd_expect("err_cnt15", 8'hF4, 32'h0, 1'b1);
        wr_reg(8'h0C, 32'hDEAD_BEEF);
        wr_reg(8'hF4, 32'hDEAD_BEEF);
        wr_reg(8'hF0, 32'h0000_0000);
        rd_expect("err_no_change_lo", 8'h04, 32'h100, 1'b0);
        rd_expect("err_no_change_cfg", 8'h00, 32'h0000_0301, 1'b0);

        // Asynchronous reset while a response is pending.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 8'h04;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pending_before_rst", {63'b0, rsp_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("async_rst_req_ready", {63'b0, req_ready}, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        rd_expect("post_rst_lo", 8'h04, 32'h0, 1'b0);
        rd_expect("post_rst_cfg", 8'h00, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
